// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers: default 640x480@60 raster,
// porch/sync arithmetic and a ceil-log2 used for counter sizing.
package vga_timing_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int timing_total(input int display, input int fp,
                                        input int sync, input int bp);
        return display + fp + sync + bp;
    endfunction

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_H_POL     = 0;
    localparam int DEF_V_POL     = 0;
    localparam int DEF_CLK_DIV   = 4;

    localparam int DEF_H_TOTAL = timing_total(DEF_H_DISPLAY, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_DISPLAY, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_COORD_W = clog2((DEF_H_TOTAL > DEF_V_TOTAL) ? DEF_H_TOTAL : DEF_V_TOTAL);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_flags_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bundle between the timing generator (master) and the pixel
// generators / connector (slave); the slave side supplies the run enable.
interface vga_sync_gen_if
    import vga_timing_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
);
    logic               en;
    logic               p_tick;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               line_end;
    logic               frame_end;

    modport master (
        input  en,
        output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_end
    );

    modport slave (
        output en,
        input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_end
    );

endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel-rate enable: divides the system clock by CLK_DIV, frozen while en is low.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic p_tick_o
);

    localparam int DIV_W = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
    typedef logic [DIV_W-1:0] div_t;
    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

    div_t cnt_q;
    div_t cnt_d;
    logic at_last;

    assign at_last = (cnt_q == DIV_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by reset so CLK_DIV=1 (count pinned at its last value) stays quiet in reset.
    assign p_tick_o = en_i & ~reset & at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster timing: pixel/line counters, sync pulses,
// blanking and line/frame strobes, advanced by the pixel tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int H_POL     = DEF_H_POL,
    parameter int V_POL     = DEF_V_POL,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int COORD_W   = DEF_COORD_W
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = timing_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_DISPLAY, V_FP, V_SYNC, V_BP);

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic   H_ACT    = 1'(H_POL);
    localparam logic   V_ACT    = 1'(V_POL);

    localparam sync_flags_t FLAGS_RST = '{hsync: ~H_ACT, vsync: ~V_ACT, video_on: 1'b0};

    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "vga_sync_gen: CLK_DIV must be at least 1");
    end
    if (clog2(H_TOTAL) > COORD_W || clog2(V_TOTAL) > COORD_W) begin : g_bad_coord
        $fatal(1, "vga_sync_gen: COORD_W cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
    if (H_DISPLAY < 1 || V_DISPLAY < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_size
        $fatal(1, "vga_sync_gen: display and sync widths must be non-zero");
    end
    if (H_POL < 0 || H_POL > 1 || V_POL < 0 || V_POL > 1) begin : g_bad_pol
        $fatal(1, "vga_sync_gen: sync polarity must be 0 or 1");
    end

    logic        p_tick;
    logic        at_line_end;
    logic        at_frame_end;
    coord_t      x_q, x_d;
    coord_t      y_q, y_d;
    sync_flags_t flags_q, flags_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .en_i     (vga.en),
        .p_tick_o (p_tick)
    );

    function automatic sync_flags_t decode(input coord_t x, input coord_t y);
        sync_flags_t f;
        f.hsync    = (x >= HS_FIRST && x <= HS_LAST) ? H_ACT : ~H_ACT;
        f.vsync    = (y >= VS_FIRST && y <= VS_LAST) ? V_ACT : ~V_ACT;
        f.video_on = (x < H_VIS) && (y < V_VIS);
        return f;
    endfunction

    assign at_line_end  = p_tick && (x_q == H_LAST);
    assign at_frame_end = at_line_end && (y_q == V_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (at_line_end) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Flags decode the next coordinates so they switch on the same edge as the counters.
    assign flags_d = decode(x_d, y_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            flags_q <= FLAGS_RST;
        end else if (vga.en) begin
            x_q     <= x_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign vga.p_tick    = p_tick;
    assign vga.pixel_x   = x_q;
    assign vga.pixel_y   = y_q;
    assign vga.hsync     = flags_q.hsync;
    assign vga.vsync     = flags_q.vsync;
    assign vga.video_on  = flags_q.video_on;
    assign vga.line_end  = at_line_end;
    assign vga.frame_end = at_frame_end;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA timing generator that produces the pixel coordinates, sync pulses and blanking flag consumed by the text/graphics generators. It is the general successor to the fixed 640x480 raster sweep: resolution, porches, sync polarity and system-clock-to-pixel-clock divide ratio are all parameters. It also adds a pixel-tick enable, line/frame strobes and a run enable. It sits between the board clock and the RGB generators and drives the VGA connector sync pins.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz
COORD_W, 10, width of pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes all counters and registered outputs
p_tick  out  1  one-clk pulse per pixel period
pixel_x  out  COORD_W  horizontal count, 0..H_TOTAL-1
pixel_y  out  COORD_W  vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per H_POL
vsync  out  1  vertical sync, polarity per V_POL
video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
line_end  out  1  one-clk pulse on the tick that wraps pixel_x to 0
frame_end  out  1  one-clk pulse on the tick that wraps both counters to 0

Behaviour:
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Reset (async, immediate, including mid-frame): div counter=0, pixel_x=0, pixel_y=0, p_tick=0, hsync=~H_POL, vsync=~V_POL, video_on=0, line_end=0, frame_end=0.
- Divider: counts 0..CLK_DIV-1 while en=1. p_tick is high for the clk in which the count equals CLK_DIV-1. With CLK_DIV=1, p_tick=en.
- Counters advance on the clk edge that ends a p_tick cycle.
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
- line_end is asserted combinationally with p_tick when pixel_x=H_TOTAL-1.
- frame_end is asserted with p_tick when pixel_x=H_TOTAL-1 and pixel_y=V_TOTAL-1. frame_end implies line_end.
- hsync, vsync and video_on are registered from the next-state counter values, so they change on the same edge as pixel_x/pixel_y (zero skew, no one-pixel lag).
  - hsync is active for H_DISPLAY+H_FP <= pixel_x < H_DISPLAY+H_FP+H_SYNC (defaults 656..751).
  - vsync is active for lines 490..491.
- First edge after reset release with en=1: video_on becomes 1 (coordinates 0,0); sync outputs stay inactive.
- en=0: divider, counters and registered outputs hold; p_tick, line_end and frame_end are 0. Resuming continues from the held divider phase.
- Counters never exceed TOTAL-1. Out-of-range widths are a parameter error, checked by an elaboration-time assertion.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default 640x480@60 constants (display, porches, sync, polarity);
  - H_TOTAL/V_TOTAL derivation;
  - a clog2 helper used to size COORD_W and the divider.
- One sub-module: pixel_tick_gen (CLK_DIV counter plus en gating, output p_tick).
- Counter and decode logic stays in vga_sync_gen.

Test Plan:
- Reset, then defaults with en=1: check reset values. The first p_tick appears 4 clks after release; pixel_x reaches 639 at clk 2559 with video_on=1, and at pixel_x=640 video_on=0.
- Full default line: hsync low exactly for pixel_x 656..751 (96 px x 4 clk = 384 clk). line_end pulses once every 3200 clk.
- Full default frame: vsync low for pixel_y 490..491. frame_end pulses every 1,680,000 clk. Coordinates wrap from (799,524) to (0,0).
- en dropped for 50 clk at pixel (100,200): outputs frozen, no p_tick. On re-enable, pixel_x=101 follows after the remaining divider phase.
- Reset asserted asynchronously mid-clock at pixel (700,300): all outputs take reset values without waiting for a clock edge. Restart from (0,0).
- Small config H_DISPLAY=8,H_FP=2,H_SYNC=3,H_BP=1,V_DISPLAY=4,V_FP=1,V_SYNC=1,V_BP=1,H_POL=1,V_POL=1,CLK_DIV=1:
  - H_TOTAL=14, V_TOTAL=7;
  - hsync high for x 10..12, vsync high on y=5;
  - frame_end every 98 clk.
